// File: rtl/add_pipe_pkg.sv
// Shared defaults, ADD/SUB mode encoding and saturation limit helper for add_pipe.
package add_pipe_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int MAX_WIDTH  = 64;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Saturation bound for a width-bit signed result: 0x80..0 when neg, else 0x7F..F.
    function automatic logic [MAX_WIDTH-1:0] sat_limit(input int width, input logic neg);
        logic [MAX_WIDTH-1:0] msb;
        msb = MAX_WIDTH'(1) << (width - 1);
        return neg ? msb : msb - MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/add_slice.sv
// One SW-bit adder slice: sum, carry out and the signed-overflow term of its MSB.
module add_slice
    import add_pipe_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          ovf
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign ovf = (a[SW-1] == b[SW-1]) & (sum[SW-1] != a[SW-1]);

endmodule

// File: rtl/add_pipe.sv
// Carry-pipelined adder/subtractor, one WIDTH/STAGES-bit slice per stage, valid/ready handshake.
// Optional clamping of overflowed results is enabled by defining ADD_PIPE_SAT_EN.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    logic adv;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Only the not-yet-added slices of b travel with the beat, so its width shrinks per stage.
        localparam int BW = WIDTH - k * SW;

        logic [WIDTH-1:0] m_i;  // result slices below k, operand-a slices from k upward
        logic [BW-1:0]    b_i;
        logic             c_i;
        logic             v_i;
        logic [WIDTH-1:0] m_o;
        logic [SW-1:0]    sum;
        logic             co;

        if (k == 0) begin : g_in
            assign m_i = a;
            assign b_i = (mode_e'(sub) == MODE_SUB) ? ~b : b;
            assign c_i = (mode_e'(sub) == MODE_SUB);
            assign v_i = in_valid;
        end else begin : g_in
            // stage k-1 -> stage k boundary
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_i <= 1'b0;
                end else if (adv) begin
                    v_i <= g_stage[k-1].v_i;
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    m_i <= g_stage[k-1].m_o;
                    b_i <= g_stage[k-1].b_i[BW+SW-1:SW];
                    c_i <= g_stage[k-1].co;
                end
            end
        end

        always_comb begin
            m_o = m_i;
            m_o[k*SW +: SW] = sum;
        end

        if (k == STAGES - 1) begin : g_last
            logic             ov;
            logic [WIDTH-1:0] res;

            add_slice #(.SW(SW)) u_slice (
                .a    (m_i[k*SW +: SW]),
                .b    (b_i[SW-1:0]),
                .cin  (c_i),
                .sum  (sum),
                .cout (co),
                .ovf  (ov)
            );

`ifdef ADD_PIPE_SAT_EN
            assign res = ov ? WIDTH'(sat_limit(WIDTH, m_i[WIDTH-1])) : m_o;
`else
            assign res = m_o;
`endif

            // last stage -> output register boundary
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_i;
                    out       <= res;
                    cout      <= co;
                    ovf       <= ov;
                    zero      <= (res == '0);
                end
            end
        end else begin : g_mid
            logic ov_unused;

            add_slice #(.SW(SW)) u_slice (
                .a    (m_i[k*SW +: SW]),
                .b    (b_i[SW-1:0]),
                .cin  (c_i),
                .sum  (sum),
                .cout (co),
                .ovf  (ov_unused)
            );
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe (WIDTH=32, STAGES=4): model results queued on accept, compared on delivery.
module tb_add_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             zero;

    typedef struct {
        logic [34:0] val;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    int          n_out   = 0;
    int          base    = 0;
    bit          chk_lat = 1'b1;
    bit          held    = 1'b0;
    logic [34:0] held_val;
    string       phase   = "reset";

    add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Packed {cout, ovf, zero, out} from signed/unsigned reference arithmetic.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint      sx, sy, sr;
        logic [32:0] u;
        logic [31:0] r;
        logic        c, v;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        sr = s ? sx - sy : sx + sy;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (s) begin
            r = x - y;
            c = (x >= y);
        end else begin
            u = {1'b0, x} + {1'b0, y};
            r = u[31:0];
            c = u[32];
        end
`ifdef ADD_PIPE_SAT_EN
        if (v) r = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return {c, v, (r == 32'd0), r};
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [34:0] got;
        got = {cout, ovf, zero, out};
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                check_eq({phase, "_stall_in_ready"}, 64'(in_ready), 64'd0);
                if (held) check_eq({phase, "_stall_hold"}, 64'(got), 64'(held_val));
                held     = 1'b1;
                held_val = got;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check_eq({phase, "_unexpected_out"}, 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq({phase, "_result"}, 64'(got), 64'(e.val));
                    if (chk_lat) check_eq({phase, "_latency"}, 64'(cyc - e.cyc), 64'(STAGES));
                end
            end
            if (in_valid && in_ready) exp_q.push_back('{val: model(a, b, sub), cyc: cyc});
        end
    end

    // Called and returns at posedge+1; holds the beat until it is accepted.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
        int n;
        n        = 0;
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq({phase, "_send_timeout"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string t);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check_eq({t, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out", 64'(out), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_zero", 64'(zero), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        phase   = "edge";
        chk_lat = 1'b1;
        send(32'h7FFF_FFFF, 32'd1, 1'b0);
        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        send(32'd5, 32'd7, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'd0, 32'd0, 1'b1);
        drain("edge");

        phase = "b2b";
        for (int i = 0; i < 16; i++) send(32'(i), 32'(32'h100 * i), 1'b0);
        drain("b2b");

        phase   = "stall";
        chk_lat = 1'b0;
        base    = n_out;
        fork
            for (int i = 0; i < 8; i++) send(32'(32'h1000_0000 * i + i), 32'(3 * i), i[0]);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stall");
        check_eq("stall_count", 64'(n_out - base), 64'd8);

        phase = "rand";
        fork
            for (int i = 0; i < 40; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
            begin
                for (int j = 0; j < 60; j++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("rand");

        phase   = "mid_reset";
        chk_lat = 1'b1;
        send(32'd11, 32'd22, 1'b0);
        send(32'd33, 32'd44, 1'b1);
        send(32'd55, 32'd66, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_out", 64'(out), 64'd0);
        check_eq("midrst_cout", 64'(cout), 64'd0);
        check_eq("midrst_ovf", 64'(ovf), 64'd0);
        check_eq("midrst_zero", 64'(zero), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_eq("midrst_release_in_ready", 64'(in_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        phase = "post_reset";
        send(32'd2, 32'd3, 1'b0);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline stages; legal 1..8; WIDTH divisible by STAGES.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  unsigned carry out (sub: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-015 SHALL have port zero  output  1  out == 0.

Function
REQ-016 SHALL split the add into STAGES slices of WIDTH/STAGES bits, slice k computed in stage k, carry registered between stages, LSB slice first.
REQ-017 SHALL, for sub=1, add ~b with carry-in 1; carry-in 0 for sub=0.
REQ-018 SHALL delay unprocessed upper operand slices and already-computed lower result slices alongside the carry so each beat's slices stay aligned.
REQ-019 SHALL have latency exactly STAGES cycles from accepted beat (in_valid & in_ready) to out_valid, with no stall.
REQ-020 SHALL sustain one beat per cycle when out_ready is held high.
REQ-021 SHALL define advance = !out_valid | out_ready; in_ready = advance; all stages shift only when advance is 1.
REQ-022 SHALL, on advance with in_valid=0, insert a bubble (stage valid 0); bubbles never raise out_valid.
REQ-023 SHALL hold out, cout, ovf, zero and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL compute ovf = (a[MSB] == b'[MSB]) & (out[MSB] != a[MSB]), where b' is the effective (possibly inverted) operand.
REQ-025 SHALL compute zero from the final out value (post-saturation when enabled).
REQ-026 SHALL behave as a registered single-cycle adder with the same handshake when STAGES=1.

Reset
REQ-027 SHALL, while rst_n=0, clear all stage valid bits, out_valid=0, out=0, cout=0, ovf=0, zero=0, independent of clk.
REQ-028 SHALL discard all in-flight beats on reset mid-operation; first post-reset output comes only from beats accepted after rst_n rises.
REQ-029 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-030 SHALL, with ADD_PIPE_SAT_EN defined, clamp out on ovf=1 to 0x7F..F (positive overflow, a[MSB]=0) or 0x80..0 (negative overflow); ovf still reports 1.
REQ-031 SHALL, without ADD_PIPE_SAT_EN, output the wrapped modulo-2^WIDTH result; no saturation logic is present.

Structure
REQ-032 SHALL place default WIDTH/STAGES constants, the mode encoding (ADD/SUB) and the saturation limit helpers in shared package add_pipe_pkg.
REQ-033 SHALL implement one slice as sub-module add_slice (operand slice, carry in -> sum slice, carry out, slice-MSB overflow term), instantiated STAGES times.

Verification (WIDTH=32, STAGES=4, out_ready=1 unless stated)
REQ-034 SHALL test: a=0x7FFFFFFF, b=1, sub=0 -> 4 cycles later out=0x80000000, ovf=1, cout=0; with ADD_PIPE_SAT_EN out=0x7FFFFFFF.
REQ-035 SHALL test: a=0xFFFFFFFF, b=1, sub=0 -> out=0, cout=1, zero=1, ovf=0; then a=5, b=7, sub=1 -> out=0xFFFFFFFE, cout=0, ovf=0.
REQ-036 SHALL test: 16 back-to-back beats a=i, b=0x100*i -> 16 results on 16 consecutive cycles, in order, first at cycle 4.
REQ-037 SHALL test: stream of 8 beats, out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, out held stable, all 8 results delivered, none lost or duplicated.
REQ-038 SHALL test: 3 beats in flight, rst_n pulsed low asynchronously between edges -> outputs zero immediately, no stale result after release; next beat a=2, b=3 yields out=5 after 4 cycles.
